max7219_chain_if: RTL
=====================

# max7219_chain_if

Serial driver for a daisy-chain of G_NB_DEVICES MAX7219 LED controllers, successor of the single-device MAX7219 interface. It accepts one 16-bit frame per device in a single wide word and shifts all 16*G_NB_DEVICES bits MSB-first on the 3-wire MAX7219 bus. It then raises LOAD once, so every device in the chain latches its own frame simultaneously. It sits between the display controllers (matrix/static layers) and the chip pins; an optional no-load mode lets upstream logic split a chain update over several transfers.

## Interface
- G_NB_DEVICES, 4: number of cascaded MAX7219 devices (≥1).
- G_MAX_HALF_PERIOD, 4: clk cycles per half period of o_max7219_clk (≥1).
- G_LOAD_DURATION, 4: clk cycles o_max7219_load stays high (≥1).
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  transfer request, sampled only in IDLE.
- i_en_load  in  1  captured with i_start; 1 = generate LOAD pulse after shifting, 0 = skip it.
- i_data  in  16*G_NB_DEVICES  frames; bits [16k+15:16k] go to device k (device 0 = closest to the FPGA).
- o_max7219_clk  out  1  serial clock to the chain.
- o_max7219_data  out  1  serial data (DIN of device 0).
- o_max7219_load  out  1  LOAD/CS to all devices.
- o_busy  out  1  high from the cycle after i_start is accepted through the last LOAD cycle.
- o_done  out  1  single-cycle pulse at the end of a transfer.

## Operation
- FSM: IDLE -> SHIFT -> LOAD -> DONE -> IDLE. If the captured i_en_load = 0, SHIFT goes directly to DONE.
- IDLE: on i_start = 1, latch i_data into a shift register of B = 16*G_NB_DEVICES bits, latch i_en_load, reset the bit and phase counters, and enter SHIFT.
- Shift order: bit B-1 first, bit 0 last. The frame of device G_NB_DEVICES-1 leaves first, so after B clocks it has propagated to the farthest device.
- Each bit occupies 2*G_MAX_HALF_PERIOD cycles:
  - o_max7219_data is updated at bit start and held stable for the whole bit.
  - o_max7219_clk is low for the first G_MAX_HALF_PERIOD cycles and high for the next G_MAX_HALF_PERIOD cycles.
  - The devices sample on the rising edge, mid-bit.
- After the last bit: o_max7219_clk = 0 and o_max7219_data = 0.
- LOAD: o_max7219_load = 1 for exactly G_LOAD_DURATION cycles, with clk and data held low.
- DONE: o_done = 1 and o_busy = 0 for one cycle. i_start during DONE is ignored; it is accepted from the following IDLE cycle.
- i_data and i_en_load changes after capture have no effect on the transfer in progress.
- i_start while busy: ignored, not queued.
- Counters: the phase counter has width clog2(2*G_MAX_HALF_PERIOD); the bit counter has width clog2(B+1). Neither counter wraps mid-transfer.

## Timing
- Reset values: o_max7219_clk = 0, o_max7219_data = 0, o_max7219_load = 0, o_busy = 0, o_done = 0, FSM = IDLE, shift register = 0.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle numbering: cycle n is the interval following rising edge n. i_start = 1 is sampled at edge 0.
- SHIFT occupies cycles 0 .. 2HB-1, with H = G_MAX_HALF_PERIOD. Bit i (counted from the first one sent) occupies cycles 2Hi .. 2Hi+2H-1.
- LOAD occupies cycles 2HB .. 2HB+L-1, with L = G_LOAD_DURATION.
- o_done fires in cycle 2HB+L, or in cycle 2HB when en_load = 0.
- o_busy is high in cycles 0 .. done-1.
- Back-to-back transfers: with i_start held high, the next transfer starts one cycle after o_done, giving a minimum gap of 2 cycles between transfers.
- Reset mid-transfer (any state): outputs return to reset values immediately and asynchronously. No LOAD pulse and no o_done are produced. The FSM is in IDLE at the first edge after rst is released.

## Test plan
- N=1, H=4, L=4, i_data=16'h0C01, en_load=1:
  - Checker receives 0x0C01 and one load pulse.
  - o_max7219_load is high in cycles 128..131; o_done is in cycle 132.
- N=2, i_data=32'hA5A5_0F01, en_load=1:
  - Checker receives 0xA5A5 then 0x0F01, followed by a single load.
  - o_done is in cycle 260; o_max7219_clk shows exactly 32 rising edges.
- N=2, en_load=0, data 32'h1234_5678:
  - Checker receives 32 bits with no load edge.
  - o_done is in cycle 256.
- Second i_start pulsed at cycle 50 of a transfer, and i_data changed at cycle 10:
  - Transmitted data equals the original capture.
  - Only one o_done occurs.
- rst asserted at cycle 100 of an N=2 transfer:
  - All outputs go to 0 within the same cycle; no load, no o_done.
  - A new transfer after reset completes normally.
- i_start held high continuously, N=1:
  - Consecutive o_done pulses are 134 cycles apart (132 + 2-cycle gap); each transfer is complete.

Source files
------------

// File: rtl/max7219_chain_if.sv
// -----------------------------------------------------------------------------
// max7219_chain_if
//   Serial driver for a daisy-chain of G_NB_DEVICES MAX7219 LED controllers.
//   One request carries a 16-bit frame per device. All 16*G_NB_DEVICES bits are
//   shifted out MSB-first on the 3-wire bus. LOAD is then pulsed once, so every
//   device latches its own frame at the same time. LOAD can be skipped so that
//   upstream logic can split one chain update over several transfers.
//
// Parameters
//   G_NB_DEVICES      number of cascaded devices (>= 1)
//   G_MAX_HALF_PERIOD clk cycles per half period of o_max7219_clk (>= 1)
//   G_LOAD_DURATION   clk cycles o_max7219_load stays high (>= 1)
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-high reset
//   i_start         transfer request, sampled only while idle
//   i_en_load       captured with i_start: 1 = pulse LOAD after shifting
//   i_data          frames, bits [16k+15:16k] go to device k (0 = nearest)
//   o_max7219_clk   serial clock to the chain
//   o_max7219_data  serial data into DIN of device 0
//   o_max7219_load  LOAD/CS to all devices
//   o_busy          high from the cycle after acceptance through the last LOAD cycle
//   o_done          one-cycle pulse when a transfer ends
// -----------------------------------------------------------------------------
module max7219_chain_if #(
  parameter int G_NB_DEVICES      = 4,
  parameter int G_MAX_HALF_PERIOD = 4,
  parameter int G_LOAD_DURATION   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_en_load,
  input  logic [16*G_NB_DEVICES-1:0]   i_data,
  output logic                         o_max7219_clk,
  output logic                         o_max7219_data,
  output logic                         o_max7219_load,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int B  = 16 * G_NB_DEVICES;
  localparam int H  = G_MAX_HALF_PERIOD;
  localparam int L  = G_LOAD_DURATION;
  localparam int PW = $clog2(2 * H);
  localparam int BW = $clog2(B + 1);
  localparam int LW = (L > 1) ? $clog2(L) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LOAD,
    S_DONE
  } state_t;

  state_t        state, state_d;
  logic [B-1:0]  shreg, shreg_d;    // bits still waiting to be sent, next one at MSB
  logic [PW-1:0] phase, phase_d;    // position inside the current bit
  logic [BW-1:0] bit_cnt, bit_cnt_d;
  logic [LW-1:0] load_cnt, load_cnt_d;
  logic          en_load, en_load_d;
  logic          sclk, sclk_d;
  logic          sdata, sdata_d;
  logic          load, load_d;
  logic          busy, busy_d;
  logic          done, done_d;

  // NOTE: every signal is given its hold value before the case statement, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state;
    shreg_d    = shreg;
    phase_d    = phase;
    bit_cnt_d  = bit_cnt;
    load_cnt_d = load_cnt;
    en_load_d  = en_load;
    sclk_d     = sclk;
    sdata_d    = sdata;
    load_d     = load;
    busy_d     = busy;
    done_d     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          // The first bit goes straight to the data pin. Only the remaining
          // bits are kept in the shift register.
          shreg_d   = {i_data[B-2:0], 1'b0};
          sdata_d   = i_data[B-1];
          en_load_d = i_en_load;
          phase_d   = '0;
          bit_cnt_d = '0;
          sclk_d    = 1'b0;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        phase_d = phase + PW'(1);
        // The clock goes high halfway through the bit, so the devices sample
        // a data value that has been stable for H cycles.
        if (phase == PW'(H - 1)) begin
          sclk_d = 1'b1;
        end
        if (phase == PW'(2 * H - 1)) begin
          phase_d = '0;
          sclk_d  = 1'b0;
          if (bit_cnt == BW'(B - 1)) begin
            sdata_d = 1'b0;
            shreg_d = '0;
            if (en_load) begin
              load_d     = 1'b1;
              load_cnt_d = '0;
              state_d    = S_LOAD;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt + BW'(1);
            sdata_d   = shreg[B-1];
            shreg_d   = {shreg[B-2:0], 1'b0};
          end
        end
      end

      S_LOAD: begin
        load_cnt_d = load_cnt + LW'(1);
        if (load_cnt == LW'(L - 1)) begin
          load_d  = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // A request seen in this cycle is dropped. Requests are accepted again
        // from the next idle cycle.
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every register is
  // updated from values taken before the clock edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      shreg    <= '0;
      phase    <= '0;
      bit_cnt  <= '0;
      load_cnt <= '0;
      en_load  <= 1'b0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      load     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      shreg    <= shreg_d;
      phase    <= phase_d;
      bit_cnt  <= bit_cnt_d;
      load_cnt <= load_cnt_d;
      en_load  <= en_load_d;
      sclk     <= sclk_d;
      sdata    <= sdata_d;
      load     <= load_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign o_max7219_clk  = sclk;
  assign o_max7219_data = sdata;
  assign o_max7219_load = load;
  assign o_busy         = busy;
  assign o_done         = done;

endmodule
